exp4_gravador_sequencia: RTL and testbench
==========================================

// Module: exp4_gravador_sequencia
// PURPOSE
//  Write side of the sequence memory: records a sequence of plays on the 4-bit switches into an
//  internal 16x4 RAM at consecutive addresses, under a start/done handshake (iniciar/pronto).
//  The existing compare datapath reads the recorded sequence back through the read port.
//  The block sits beside the comparison datapath and feeds the same hexa7seg debug displays.
// PARAMETERS
//  PROFUNDIDADE    16     RAM depth in words; address width is $clog2(PROFUNDIDADE) = 4
//  TIMEOUT_CICLOS  5000   idle cycles allowed in ESPERA before timeout (GRAVADOR_TIMEOUT_EN only)
// PORTS
//  clock         in   1  single clock; all state updates on rising edge
//  reset         in   1  asynchronous, active-low; reset=0 forces the reset state immediately
//  iniciar       in   1  start request, level-sampled
//  chaves        in   4  play input; a play is a 0 -> nonzero transition
//  limite        in   4  index of the last play to record; records limite+1 plays
//  end_leitura   in   4  read address for the compare datapath
//  dado_leitura  out  4  RAM word at end_leitura, 1-cycle synchronous read
//  pronto        out  1  high while in FIM
//  timeout       out  1  high while in TIMEOUT; tied 0 without the macro
//  db_jogada     out  1  one-cycle pulse when a play is detected
//  db_contagem   out  4  current write address
//  db_memoria    out  4  last value written
//  db_estado     out  4  state code, for the hexa7seg debug display
// BEHAVIOUR
//  Reset (reset=0): state INICIAL. pronto, timeout, db_jogada and db_contagem = 0. db_memoria = 0.
//   Sync-stage and edge registers = 0. RAM contents are not cleared. dado_leitura = 0 until the first read after reset.
//  Input sync: chaves passes through 2 flops. jogada = (prev==0) && (cur!=0), evaluated on the synced value.
//   Play latency from a chaves change to the jogada pulse is 2-3 cycles. Nonzero-to-nonzero changes are not plays.
//  FSM (db_estado code):
//   INICIAL(0)   iniciar=1 -> PREPARA
//   PREPARA(1)   contagem <= 0; limite_reg <= limite; edge detector re-armed -> ESPERA
//   ESPERA(2)    jogada=1 -> REGISTRA, capturing the synced chaves into dado_reg
//   REGISTRA(3)  we=1 for exactly this cycle, writes dado_reg at address contagem; db_memoria <= dado_reg
//                contagem==limite_reg -> FIM, else -> PROXIMO
//   PROXIMO(4)   contagem <= contagem+1 -> ESPERA
//   FIM(F)       pronto=1 and held; contagem frozen; iniciar=1 -> PREPARA (new recording)
//   TIMEOUT(E)   macro builds only; timeout=1 and held; iniciar=1 -> PREPARA
//  iniciar is ignored in states 1-4; a recording cannot be restarted mid-sequence except by reset.
//  limite is sampled only in PREPARA; later changes have no effect on the current recording.
//  limite=F with PROFUNDIDADE=16 fills addresses 0..F. contagem never wraps past limite_reg.
//  Plays arriving in REGISTRA or PROXIMO are not lost only if they are still pending (prev==0) at the next ESPERA cycle.
//  Otherwise they are dropped; a bench must space plays at least 4 cycles apart.
//  Same-cycle read and write to one address: dado_leitura returns the old word; the new word appears on the next read.
//  Reset mid-recording: next state is INICIAL; words already written are kept.
// CONFIGURATION
//  GRAVADOR_TIMEOUT_EN defined:
//   An idle counter clears on entry to ESPERA and counts every ESPERA cycle.
//   At TIMEOUT_CICLOS-1 with no jogada, the next state is TIMEOUT.
//   A jogada on the expiry cycle takes priority: the next state is REGISTRA.
//  GRAVADOR_TIMEOUT_EN undefined:
//   No idle counter. ESPERA waits indefinitely. timeout is constant 0. TIMEOUT_CICLOS is unused.
// STRUCTURE
//  Shared package/header exp4_defs:
//   state codes (E_INICIAL..E_TIMEOUT, 4-bit)
//   DATA_W=4
//  Sub-module ram_seq_16x4 holds the memory:
//   write port: clock, we, end_escrita, dado_escrita
//   read port: end_leitura, dado_leitura, registered
//  This file holds the sync/edge logic, the FSM, the counter and the optional timeout counter.
// TESTING
//  1 Hold reset=0 with random inputs -> db_estado=0, pronto=0, db_contagem=0. Release; iniciar held 0 -> stays in INICIAL.
//  2 limite=3, iniciar pulse, plays 1,2,4,8 spaced 10 cycles -> pronto=1, db_contagem=3, db_memoria=8.
//    Then end_leitura 0..3 -> dado_leitura 1,2,4,8, each 1 cycle after its address.
//  3 limite=F, 16 plays of values 1..F,1 -> addresses 0..F written; db_contagem stops at F, no wrap. pronto=1.
//  4 chaves held at 4, then changed to 2 without returning to 0 -> no db_jogada pulse.
//    Next 0 -> 8 transition -> one pulse, and 8 is written.
//  5 reset=0 asserted in the middle of a play -> async return to state 0. Earlier words still read back. New iniciar restarts at address 0.
//  6 GRAVADOR_TIMEOUT_EN, TIMEOUT_CICLOS=20, no play -> TIMEOUT(E) 20 cycles after entering ESPERA, timeout=1.
//    iniciar -> PREPARA, timeout=0.
//    Without the macro, the same stimulus stays in ESPERA for 1000 cycles.

Source files
------------

// File: rtl/exp4_gravador_sequencia_pkg.sv
// Shared definitions for the sequence recorder: FSM state codes shown on the
// debug display and the data width of one play.
package exp4_defs;

   localparam int DATA_W = 4;

   typedef enum logic [3:0] {
      E_INICIAL  = 4'h0,
      E_PREPARA  = 4'h1,
      E_ESPERA   = 4'h2,
      E_REGISTRA = 4'h3,
      E_PROXIMO  = 4'h4,
      E_TIMEOUT  = 4'hE,
      E_FIM      = 4'hF
   } estado_t;

endpackage

// File: rtl/exp4_gravador_sequencia_ram.sv
// Sequence memory: one synchronous write port and one registered read port.
// A read of the address being written returns the old word.
module ram_seq_16x4
   import exp4_defs::*;
#(
   parameter  int PROFUNDIDADE = 16,
   localparam int AW           = $clog2(PROFUNDIDADE)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     end_escrita,
   input  logic [DATA_W-1:0] dado_escrita,
   input  logic [AW-1:0]     end_leitura,
   output logic [DATA_W-1:0] dado_leitura
);

   logic [DATA_W-1:0] r_mem [PROFUNDIDADE];
   logic [DATA_W-1:0] r_dado_leitura;

   // NOTE: the array has no reset so it maps onto RAM; recorded words survive a reset.
   always_ff @(posedge clock) begin
      if (we) r_mem[end_escrita] <= dado_escrita;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_dado_leitura <= '0;
      else        r_dado_leitura <= r_mem[end_leitura];
   end

   assign dado_leitura = r_dado_leitura;

endmodule

// File: rtl/exp4_gravador_sequencia.sv
// Records limite+1 plays from the switches into ram_seq_16x4 under an iniciar/pronto
// handshake. Define GRAVADOR_TIMEOUT_EN to add the ESPERA idle timeout.
module exp4_gravador_sequencia
   import exp4_defs::*;
#(
   parameter  int PROFUNDIDADE   = 16,
   parameter  int TIMEOUT_CICLOS = 5000,
   localparam int AW             = $clog2(PROFUNDIDADE)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic [DATA_W-1:0] chaves,
   input  logic [AW-1:0]     limite,
   input  logic [AW-1:0]     end_leitura,
   output logic [DATA_W-1:0] dado_leitura,
   output logic              pronto,
   output logic              timeout,
   output logic              db_jogada,
   output logic [AW-1:0]     db_contagem,
   output logic [DATA_W-1:0] db_memoria,
   output logic [3:0]        db_estado
);

   if (TIMEOUT_CICLOS < 2 || PROFUNDIDADE < 2) begin : g_param_invalido
      $error("exp4_gravador_sequencia: PROFUNDIDADE and TIMEOUT_CICLOS must be >= 2");
   end

   estado_t           r_estado;
   logic [DATA_W-1:0] r_sync1, r_sync2, r_prev;
   logic [DATA_W-1:0] r_dado, r_memoria;
   logic [AW-1:0]     r_contagem, r_limite;
   logic              r_we, r_pronto;
   logic              w_jogada;
   logic              w_expirou;

   // The edge register follows the synced value every cycle, so a play is only
   // seen while it is fresh and nothing stale can fire after PREPARA.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         // NOTE: non-blocking assignments make the three stages shift together.
         r_sync1 <= chaves;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_jogada = (r_prev == '0) && (r_sync2 != '0);

`ifdef GRAVADOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
   logic [TW-1:0] r_ociosos;
   logic          r_timeout;

   // Held at zero outside ESPERA, so every entry into ESPERA starts a fresh count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                   r_ociosos <= '0;
      else if (r_estado != E_ESPERA) r_ociosos <= '0;
      else                          r_ociosos <= r_ociosos + 1'b1;
   end

   assign w_expirou = (r_ociosos == TW'(TIMEOUT_CICLOS - 1));
   assign timeout   = r_timeout;
`else
   assign w_expirou = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado   <= E_INICIAL;
         r_contagem <= '0;
         r_limite   <= '0;
         r_dado     <= '0;
         r_memoria  <= '0;
         r_we       <= 1'b0;
         r_pronto   <= 1'b0;
`ifdef GRAVADOR_TIMEOUT_EN
         r_timeout  <= 1'b0;
`endif
      end else begin
         r_we <= 1'b0;
         case (r_estado)
            E_INICIAL: if (iniciar) r_estado <= E_PREPARA;
            E_PREPARA: begin
               r_contagem <= '0;
               r_limite   <= limite;
               r_estado   <= E_ESPERA;
            end
            E_ESPERA: begin
               // A play on the expiry cycle wins over the timeout.
               if (w_jogada) begin
                  r_dado   <= r_sync2;
                  r_we     <= 1'b1;
                  r_estado <= E_REGISTRA;
               end else if (w_expirou) begin
                  r_estado  <= E_TIMEOUT;
`ifdef GRAVADOR_TIMEOUT_EN
                  r_timeout <= 1'b1;
`endif
               end
            end
            E_REGISTRA: begin
               r_memoria <= r_dado;
               if (r_contagem == r_limite) begin
                  r_estado <= E_FIM;
                  r_pronto <= 1'b1;
               end else begin
                  r_estado <= E_PROXIMO;
               end
            end
            E_PROXIMO: begin
               r_contagem <= r_contagem + 1'b1;
               r_estado   <= E_ESPERA;
            end
            E_FIM: begin
               if (iniciar) begin
                  r_estado <= E_PREPARA;
                  r_pronto <= 1'b0;
               end
            end
`ifdef GRAVADOR_TIMEOUT_EN
            E_TIMEOUT: begin
               if (iniciar) begin
                  r_estado  <= E_PREPARA;
                  r_timeout <= 1'b0;
               end
            end
`endif
            default: r_estado <= E_INICIAL;
         endcase
      end
   end

   ram_seq_16x4 #(.PROFUNDIDADE(PROFUNDIDADE)) u_ram (
      .clock        (clock),
      .reset        (reset),
      .we           (r_we),
      .end_escrita  (r_contagem),
      .dado_escrita (r_dado),
      .end_leitura  (end_leitura),
      .dado_leitura (dado_leitura)
   );

   assign pronto      = r_pronto;
   assign db_jogada   = w_jogada;
   assign db_contagem = r_contagem;
   assign db_memoria  = r_memoria;
   assign db_estado   = r_estado;

endmodule

// File: tb/tb_exp4_gravador_sequencia.sv
// Directed bench for exp4_gravador_sequencia: read-back tables plus hand-written
// sequences for reset, non-plays, read/write collision and the idle timeout.
module tb_exp4_gravador_sequencia;

   typedef struct {
      logic [3:0] end_l;
      logic [3:0] esperado;
   } leitura_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic [3:0] chaves = '0;
   logic [3:0] limite = '0;
   logic [3:0] end_leitura = '0;
   logic [3:0] dado_leitura;
   logic       pronto, timeout, db_jogada;
   logic [3:0] db_contagem, db_memoria, db_estado;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pulsos = 0;

   leitura_t t_seq4 [4];
   leitura_t t_seq16 [16];

   exp4_gravador_sequencia #(.PROFUNDIDADE(16), .TIMEOUT_CICLOS(20)) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .chaves       (chaves),
      .limite       (limite),
      .end_leitura  (end_leitura),
      .dado_leitura (dado_leitura),
      .pronto       (pronto),
      .timeout      (timeout),
      .db_jogada    (db_jogada),
      .db_contagem  (db_contagem),
      .db_memoria   (db_memoria),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (db_jogada === 1'b1) n_pulsos++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_tests++;
      if (atual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
      end
   endtask

   task automatic iniciar_gravacao(input logic [3:0] lim);
      limite  = lim;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
   endtask

   task automatic jogar(input logic [3:0] v);
      chaves = '0;
      tick(5);
      chaves = v;
      tick(5);
   endtask

   task automatic esperar_estado(input logic [3:0] e, input int limite_ciclos, input string nome);
      int k = 0;
      while (db_estado !== e && k < limite_ciclos) begin
         tick();
         k++;
      end
      check(nome, db_estado, e);
   endtask

   task automatic ler(input logic [3:0] a, input logic [3:0] esperado, input string nome);
      end_leitura = a;
      tick();
      check(nome, dado_leitura, esperado);
   endtask

   initial begin
      int p0;
      t_seq4[0] = '{4'h0, 4'h1};
      t_seq4[1] = '{4'h1, 4'h2};
      t_seq4[2] = '{4'h2, 4'h4};
      t_seq4[3] = '{4'h3, 4'h8};
      for (int i = 0; i < 15; i++) t_seq16[i] = '{4'(i), 4'(i + 1)};
      t_seq16[15] = '{4'hF, 4'h1};

      // 1: reset with random inputs
      for (int i = 0; i < 5; i++) begin
         chaves      = 4'($urandom);
         limite      = 4'($urandom);
         end_leitura = 4'($urandom);
         iniciar     = 1'($urandom);
         tick();
      end
      check("rst_estado", db_estado, 4'h0);
      check("rst_pronto", pronto, 1'b0);
      check("rst_contagem", db_contagem, 4'h0);
      check("rst_memoria", db_memoria, 4'h0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_dado_leitura", dado_leitura, 4'h0);
      check("rst_jogada", db_jogada, 1'b0);
      chaves = '0; iniciar = 1'b0; end_leitura = '0;
      reset = 1'b1;
      tick(5);
      check("idle_inicial", db_estado, 4'h0);

      // 2: limite=3, plays 1,2,4,8; limite change and iniciar after PREPARA ignored
      iniciar_gravacao(4'h3);
      check("t2_prepara", db_estado, 4'h1);
      tick();
      check("t2_espera", db_estado, 4'h2);
      limite  = 4'h0;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      check("t2_iniciar_ignorado", db_estado, 4'h2);
      jogar(4'h1);
      jogar(4'h2);
      jogar(4'h4);
      check("t2_not_pronto_yet", pronto, 1'b0);
      jogar(4'h8);
      esperar_estado(4'hF, 20, "t2_fim");
      check("t2_pronto", pronto, 1'b1);
      check("t2_contagem", db_contagem, 4'h3);
      check("t2_memoria", db_memoria, 4'h8);
      for (int i = 0; i < 4; i++) ler(t_seq4[i].end_l, t_seq4[i].esperado, $sformatf("t2_read_%0d", i));

      // 3: limite=F fills all 16 addresses, no wrap
      iniciar_gravacao(4'hF);
      for (int i = 0; i < 16; i++) jogar(t_seq16[i].esperado);
      esperar_estado(4'hF, 20, "t3_fim");
      tick(10);
      check("t3_estado_held", db_estado, 4'hF);
      check("t3_pronto", pronto, 1'b1);
      check("t3_contagem", db_contagem, 4'hF);
      check("t3_memoria", db_memoria, 4'h1);
      for (int i = 0; i < 16; i++) ler(t_seq16[i].end_l, t_seq16[i].esperado, $sformatf("t3_read_%0d", i));

      // 4: nonzero-to-nonzero change is not a play
      iniciar_gravacao(4'h1);
      jogar(4'h4);
      check("t4_contagem_after_4", db_contagem, 4'h1);
      p0 = n_pulsos;
      chaves = 4'h2;
      tick(8);
      check("t4_no_pulse", n_pulsos, p0);
      check("t4_still_espera", db_estado, 4'h2);
      check("t4_contagem_held", db_contagem, 4'h1);
      jogar(4'h8);
      check("t4_one_pulse", n_pulsos, p0 + 1);
      esperar_estado(4'hF, 20, "t4_fim");
      check("t4_memoria", db_memoria, 4'h8);
      ler(4'h0, 4'h4, "t4_read_0");
      ler(4'h1, 4'h8, "t4_read_1");

      // 5: reset in the middle of a play
      iniciar_gravacao(4'hF);
      jogar(4'h5);
      chaves = '0;
      tick(5);
      chaves = 4'h6;
      tick();
      reset = 1'b0;
      #1;
      check("t5_async_estado", db_estado, 4'h0);
      check("t5_async_contagem", db_contagem, 4'h0);
      tick(2);
      reset = 1'b1;
      chaves = '0;
      tick(2);
      check("t5_estado_after", db_estado, 4'h0);
      ler(4'h0, 4'h5, "t5_read_0");
      ler(4'h1, 4'h8, "t5_read_1");
      ler(4'h2, 4'h3, "t5_read_2");

      // 5b: restart at address 0; same-cycle read/write returns old word
      end_leitura = 4'h0;
      iniciar_gravacao(4'h2);
      tick();
      check("t5_restart_contagem", db_contagem, 4'h0);
      tick(4);
      chaves = 4'h9;
      esperar_estado(4'h3, 10, "t5_registra");
      tick();
      check("t5_raw_old", dado_leitura, 4'h5);
      tick();
      check("t5_raw_new", dado_leitura, 4'h9);
      check("t5_memoria", db_memoria, 4'h9);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chaves = '0;
      tick(2);

      // 6: idle behaviour in ESPERA
      iniciar_gravacao(4'h0);
      check("t6_prepara", db_estado, 4'h1);
      tick();
      check("t6_espera", db_estado, 4'h2);
`ifdef GRAVADOR_TIMEOUT_EN
      tick(19);
      check("t6_before_expiry", db_estado, 4'h2);
      check("t6_timeout_low", timeout, 1'b0);
      tick();
      check("t6_timeout_state", db_estado, 4'hE);
      check("t6_timeout_high", timeout, 1'b1);
      tick(5);
      check("t6_timeout_held", timeout, 1'b1);
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      check("t6_restart_prepara", db_estado, 4'h1);
      check("t6_timeout_cleared", timeout, 1'b0);
`else
      tick(1000);
      check("t6_still_espera", db_estado, 4'h2);
      check("t6_timeout_zero", timeout, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
